// File: rtl/reg_p2s.sv
// Parallel-to-serial readout: shifts a captured word out over a three-wire
// serial link (clock, data, load strobe) with a programmable clock divider.
module reg_p2s #(
  parameter int WIDTH     = 32,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             sout_clk,
  output logic             sout_data,
  output logic             sout_load
);

  localparam int DCW = $clog2(DIV) + 1;
  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t           state, state_nxt;
  logic [DCW-1:0]   div_cnt, div_nxt;
  logic [BCW-1:0]   bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             busy_nxt, done_nxt, clk_nxt, data_nxt, load_nxt;

  logic [WIDTH-1:0] shifted;
  logic             first_bit, next_bit, div_end;

  always_comb begin
    shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    first_bit = MSB_FIRST ? D[WIDTH-1] : D[0];
    next_bit  = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
    div_end   = (div_cnt == DIV_LAST);
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    clk_nxt   = sout_clk;
    data_nxt  = sout_data;
    load_nxt  = sout_load;
    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        clk_nxt  = 1'b0;
        load_nxt = 1'b0;
        data_nxt = 1'b0;
        if (start) begin
          state_nxt = SHIFT_LO;
          div_nxt   = '0;
          bit_nxt   = BCW'(WIDTH);
          shreg_nxt = D;
          busy_nxt  = 1'b1;
          data_nxt  = first_bit;
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          state_nxt = SHIFT_HI;
          div_nxt   = '0;
          clk_nxt   = 1'b1;
        end else begin
          div_nxt = div_cnt + DCW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_nxt = '0;
          bit_nxt = bit_cnt - BCW'(1);
          clk_nxt = 1'b0;
          // A count of one here means the bit just clocked was the last one.
          if (bit_cnt != BCW'(1)) begin
            state_nxt = SHIFT_LO;
            shreg_nxt = shifted;
            data_nxt  = next_bit;
          end else begin
            state_nxt = LATCH;
            load_nxt  = 1'b1;
          end
        end else begin
          div_nxt = div_cnt + DCW'(1);
        end
      end
      LATCH: begin
        if (div_end) begin
          state_nxt = DONE;
          div_nxt   = '0;
          load_nxt  = 1'b0;
          data_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          div_nxt = div_cnt + DCW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        div_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sout_clk  <= 1'b0;
      sout_data <= 1'b0;
      sout_load <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      sout_clk  <= clk_nxt;
      sout_data <= data_nxt;
      sout_load <= load_nxt;
    end
  end

endmodule

// File: tb/tb_reg_p2s.sv
// Testbench for reg_p2s: a serial-receiver model rebuilds each shifted word
// and measures latency, strobe width and link-timing rules on two configurations.
module tb_reg_p2s;

  localparam int W      = 32;
  localparam int DIV_A  = 2;
  localparam int DIV_B  = 1;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [W-1:0] d_a, d_b;
  logic busy_a, done_a, sclk_a, sdata_a, load_a;
  logic busy_b, done_b, sclk_b, sdata_b, load_b;

  always #5 clk = ~clk;

  reg_p2s #(.WIDTH(W), .DIV(DIV_A), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .D(d_a),
    .busy(busy_a), .done(done_a), .sout_clk(sclk_a),
    .sout_data(sdata_a), .sout_load(load_a)
  );

  reg_p2s #(.WIDTH(W), .DIV(DIV_B), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .D(d_b),
    .busy(busy_b), .done(done_b), .sout_clk(sclk_b),
    .sout_data(sdata_b), .sout_load(load_b)
  );

  int compared = 0;
  int mismatched = 0;

  // Receiver-side record of each completed transfer.
  int          done_q[$];
  logic [31:0] word_q[$];
  int          bits_q[$];
  int          load_q[$];
  int          anomalies;
  int          inject_at = -1;
  logic [31:0] inject_d = '0;

  typedef struct {
    int          which;
    logic [31:0] d;
    logic        first;
    int          lat;
    int          loads;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [4:0] outs(input int which);
    return (which != 0) ? {busy_b, done_b, sclk_b, sdata_b, load_b}
                        : {busy_a, done_a, sclk_a, sdata_a, load_a};
  endfunction

  function automatic int div_of(input int which);
    return (which != 0) ? DIV_B : DIV_A;
  endfunction

  task automatic set_in(input int which, input logic s, input logic [31:0] d);
    if (which != 0) begin start_b = s; d_b = d; end
    else begin start_a = s; d_a = d; end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for the DUT to be idle, then strobes start so the next edge is E0.
  task automatic applyStimulus(input int which, input logic [31:0] w,
                               input logic exp_first, input bit hold);
    logic [4:0] o;
    int guard;
    guard = 0;
    @(negedge clk);
    o = outs(which);
    while ((o[4] || o[3]) && guard < 400) begin
      @(negedge clk);
      o = outs(which);
      guard++;
    end
    checkOutput("idle_wait", int'(guard < 400), 1);
    set_in(which, 1'b1, w);
    @(posedge clk);
    #1;
    if (!hold) set_in(which, 1'b0, w);
    o = outs(which);
    checkOutput("busy_at_e0", int'(o[4]), 1);
    checkOutput("first_bit", int'(o[1]), int'(exp_first));
  endtask

  // Serial receiver: samples sout_data on each sout_clk rise and rebuilds the word.
  task automatic observe(input int which, input int n_dones, input int budget);
    logic [4:0] o;
    logic bz, dn, sc, sd, ld, psc, psd, pbz;
    logic [31:0] cur_word;
    int cur_bits, cur_loads, cyc, pos;
    done_q.delete(); word_q.delete(); bits_q.delete(); load_q.delete();
    anomalies = 0;
    cur_word = '0; cur_bits = 0; cur_loads = 0; cyc = 0;
    o = outs(which);
    {pbz, dn, psc, psd, ld} = o;
    while (cyc < budget && done_q.size() < n_dones) begin
      @(posedge clk);
      #1;
      cyc++;
      {bz, dn, sc, sd, ld} = outs(which);
      if (sc && !psc) begin
        pos = (which == 0) ? (W - 1 - cur_bits) : cur_bits;
        if (cur_bits < W) cur_word[pos] = sd;
        cur_bits++;
      end
      if (ld) cur_loads++;
      if (sc && ld) anomalies++;
      if (dn && bz) anomalies++;
      if ((sd != psd) && !(psc && !sc) && !dn && pbz) anomalies++;
      if (dn) begin
        done_q.push_back(cyc);
        word_q.push_back(cur_word);
        bits_q.push_back(cur_bits);
        load_q.push_back(cur_loads);
        cur_word = '0; cur_bits = 0; cur_loads = 0;
      end
      if (cyc == inject_at) set_in(which, 1'b1, inject_d);
      if (cyc == inject_at + 1) set_in(which, 1'b0, inject_d);
      psc = sc; psd = sd; pbz = bz;
    end
  endtask

  task automatic checkTransfer(input int which, input logic [31:0] exp_word,
                               input int exp_lat, input int exp_loads);
    checkOutput("done_seen", done_q.size(), 1);
    if (done_q.size() > 0) begin
      checkOutput("latency", done_q[0], exp_lat);
      checkOutput("word", int'(word_q[0]), int'(exp_word));
      checkOutput("bit_count", bits_q[0], W);
      checkOutput("load_cycles", load_q[0], exp_loads);
    end
    checkOutput("link_rules", anomalies, 0);
  endtask

  initial begin
    logic [31:0] w;
    int which;

    rst = 1'b1;
    set_in(0, 1'b1, 32'hAAAA_5555);
    set_in(1, 1'b0, 32'h0);

    // Reset held with start high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_outs_a", int'(outs(0)), 0);
      checkOutput("reset_outs_b", int'(outs(1)), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 32'hAAAA_5555);
    checkOutput("busy_after_release", int'(busy_a), 1);
    observe(0, 1, 400);
    checkTransfer(0, 32'hAAAA_5555, (2 * W + 1) * DIV_A, DIV_A);

    // Directed vectors.
    vecs[0] = '{0, 32'h8000_0001, 1'b1, 130, 2};
    vecs[1] = '{1, 32'h0000_00A5, 1'b1, 65, 1};
    vecs[2] = '{0, 32'h0000_0000, 1'b0, 130, 2};
    vecs[3] = '{1, 32'h8000_0000, 1'b0, 65, 1};
    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d: dut %0d D=%08h", i, vecs[i].which, vecs[i].d);
      applyStimulus(vecs[i].which, vecs[i].d, vecs[i].first, 1'b0);
      observe(vecs[i].which, 1, 400);
      checkTransfer(vecs[i].which, vecs[i].d, vecs[i].lat, vecs[i].loads);
    end

    // Start while busy is ignored and not queued.
    applyStimulus(0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    inject_at = 40;
    inject_d = 32'h1234_5678;
    observe(0, 1, 400);
    inject_at = -1;
    checkTransfer(0, 32'hFFFF_FFFF, 130, 2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_queued_start", int'(busy_a), 0);
    end

    // Back-to-back: one DONE cycle plus one IDLE cycle between transfers.
    applyStimulus(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    observe(0, 2, 600);
    set_in(0, 1'b0, 32'hDEAD_BEEF);
    checkOutput("b2b_dones", done_q.size(), 2);
    if (done_q.size() == 2) begin
      checkOutput("b2b_first_lat", done_q[0], 130);
      checkOutput("b2b_spacing", done_q[1] - done_q[0], 130 + 2);
      checkOutput("b2b_word0", int'(word_q[0]), int'(32'hDEAD_BEEF));
      checkOutput("b2b_word1", int'(word_q[1]), int'(32'hDEAD_BEEF));
    end
    checkOutput("b2b_link_rules", anomalies, 0);

    // Reset in mid-transfer aborts it with no done pulse.
    applyStimulus(0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    observe(0, 1, 49);
    checkOutput("no_early_done", done_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_reset_outs", int'(outs(0)), 0);
    @(negedge clk);
    rst = 1'b0;
    observe(0, 1, 200);
    checkOutput("aborted_no_done", done_q.size(), 0);
    checkOutput("aborted_no_clk", bits_q.size() + int'(sclk_a), 0);
    applyStimulus(0, 32'h3C3C_A5A5, 1'b0, 1'b0);
    observe(0, 1, 400);
    checkTransfer(0, 32'h3C3C_A5A5, 130, 2);

    // Randomized words on both configurations.
    for (int i = 0; i < 6; i++) begin
      which = i % 2;
      w = $urandom;
      applyStimulus(which, w, (which == 0) ? w[31] : w[0], 1'b0);
      observe(which, 1, 400);
      checkTransfer(which, w, (2 * W + 1) * div_of(which), div_of(which));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
